// File: rtl/csr_file_param_if.sv
// csr_file_param_if
// CSR access port between the pipeline and the CSR file.
//   master (pipeline):  drives csr_we/csr_waddr/csr_wdata/csr_wmask from WB
//                       and csr_raddr from EX; receives csr_rdata.
//   slave  (CSR file):  receives the write and read requests; returns
//                       csr_rdata combinationally.
interface csr_file_param_if;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;

  modport master (
    output csr_we, csr_waddr, csr_wdata, csr_wmask, csr_raddr,
    input  csr_rdata
  );

  modport slave (
    input  csr_we, csr_waddr, csr_wdata, csr_wmask, csr_raddr,
    output csr_rdata
  );
endinterface

// File: rtl/csr_file_param.sv
// csr_file_param
// Parametrised LoongArch-style CSR file: CRMD, PRMD, ECFG, ESTAT, ERA, BADV,
// EENTRY, SAVE0..SAVE(NUM_SAVE-1), TID, TCFG, TVAL, TICLR.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   csr_bus (slave)   masked CSR write port (WB) and combinational read (EX)
//   hwi_in, ipi_in    interrupt lines, sampled through 1 or 2 flops
//   exc_*             exception commit: ecode/subcode, PC, optional BADV
//   ertn              exception return (takes priority over exc_sig)
//   eentry_out        EENTRY with same-cycle write bypass, bits [5:0] zero
//   era_out           ERA with same-cycle write bypass
//   int_out           any enabled pending interrupt, gated by CRMD.IE
module csr_file_param #(
  parameter int          TIMER_WIDTH = 32,
  parameter int          NUM_SAVE    = 4,
  parameter int          HWI_SYNC    = 1,
  parameter logic [31:0] TID_RESET   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  csr_file_param_if.slave        csr_bus,
  input  logic [7:0]             hwi_in,
  input  logic                   ipi_in,
  input  logic                   exc_sig,
  input  logic [5:0]             exc_ecode,
  input  logic [8:0]             exc_esubcode,
  input  logic [31:0]            exc_pc,
  input  logic                   exc_badv_we,
  input  logic [31:0]            exc_badv,
  input  logic                   ertn,
  output logic [31:0]            eentry_out,
  output logic [31:0]            era_out,
  output logic                   int_out
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00C;
  localparam logic [13:0] ADDR_SAVE0  = 14'h030;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_TCFG   = 14'h041;
  localparam logic [13:0] ADDR_TVAL   = 14'h042;
  localparam logic [13:0] ADDR_TICLR  = 14'h044;

  // Software-writable bit masks; everything outside them is held/reads 0.
  localparam logic [31:0] W_CRMD   = 32'h0000_001F;
  localparam logic [31:0] W_PRMD   = 32'h0000_0007;
  localparam logic [31:0] W_ECFG   = 32'h0000_1BFF;
  localparam logic [31:0] W_EENTRY = 32'hFFFF_FFC0;
  localparam logic [31:0] W_ALL    = 32'hFFFF_FFFF;
  localparam logic [31:0] W_TCFG   = 32'((64'd1 << TIMER_WIDTH) - 64'd1);

  localparam logic [31:0] SAVE_END   = 32'(48 + NUM_SAVE);
  localparam int          SIDX_W     = (NUM_SAVE > 1) ? $clog2(NUM_SAVE) : 1;
  localparam int          SAVE_DEPTH = 1 << SIDX_W;

  localparam logic [TIMER_WIDTH-1:0] TIMER_ZERO = {TIMER_WIDTH{1'b0}};
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

  // Masked merge of a write into an old value, limited to writable bits.
  function automatic logic [31:0] merge_wr(input logic [31:0] old_v,
                                           input logic [31:0] wdata,
                                           input logic [31:0] wmask,
                                           input logic [31:0] wr_bits);
    logic [31:0] m;
    m = wmask & wr_bits;
    return (old_v & ~m) | (wdata & m);
  endfunction

  logic [31:0] crmd_r, prmd_r, ecfg_r, era_r, badv_r, eentry_r, tid_r, tcfg_r;
  logic [31:0] save_r [SAVE_DEPTH];
  logic [1:0]  swi_r;
  logic [7:0]  hwi_r;
  logic        ipi_r, ti_r;
  logic [5:0]  ecode_r;
  logic [8:0]  esub_r;
  logic [TIMER_WIDTH-1:0] timer_r;

  logic [8:0]  irq_smp_s;
  logic        wr_crmd_s, wr_prmd_s, wr_ecfg_s, wr_estat_s, wr_era_s, wr_badv_s;
  logic        wr_eentry_s, wr_tid_s, wr_tcfg_s, wr_ticlr_s, save_wr_s, save_rhit_s;
  logic [31:0] crmd_post_s, prmd_post_s, ecfg_post_s, era_post_s, badv_post_s;
  logic [31:0] eentry_post_s, tid_post_s, tcfg_post_s, save_wv_s, save_rv_s;
  logic [31:0] crmd_nxt_s, prmd_nxt_s, estat_view_s, rdata_s;
  logic [1:0]  swi_post_s;
  logic [12:0] is_s;
  logic [SIDX_W-1:0] widx_s, ridx_s;
  logic        ticlr_s, expire_s, exc_take_s;

  generate
    if (HWI_SYNC != 0) begin : g_sync2
      logic [8:0] meta_r;
      // First synchroniser stage for {ipi, hwi}; ESTAT holds the second.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) meta_r <= 9'h000;
        else     meta_r <= {ipi_in, hwi_in};
      end
      assign irq_smp_s = meta_r;
    end else begin : g_sync1
      assign irq_smp_s = {ipi_in, hwi_in};
    end
  endgenerate

  assign wr_crmd_s   = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_CRMD);
  assign wr_prmd_s   = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_PRMD);
  assign wr_ecfg_s   = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_ECFG);
  assign wr_estat_s  = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_ESTAT);
  assign wr_era_s    = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_ERA);
  assign wr_badv_s   = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_BADV);
  assign wr_eentry_s = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_EENTRY);
  assign wr_tid_s    = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_TID);
  assign wr_tcfg_s   = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_TCFG);
  assign wr_ticlr_s  = csr_bus.csr_we && (csr_bus.csr_waddr == ADDR_TICLR);
  assign save_wr_s   = csr_bus.csr_we && (csr_bus.csr_waddr >= ADDR_SAVE0)
                       && ({18'h00000, csr_bus.csr_waddr} < SAVE_END);
  assign save_rhit_s = (csr_bus.csr_raddr >= ADDR_SAVE0)
                       && ({18'h00000, csr_bus.csr_raddr} < SAVE_END);
  // SAVE0 sits on a 16-aligned address, so the low bits are the bank index.
  assign widx_s = csr_bus.csr_waddr[SIDX_W-1:0];
  assign ridx_s = csr_bus.csr_raddr[SIDX_W-1:0];

  // Post-write views: equal to the register unless this cycle writes it.
  assign crmd_post_s   = wr_crmd_s   ? merge_wr(crmd_r,   csr_bus.csr_wdata, csr_bus.csr_wmask, W_CRMD)   : crmd_r;
  assign prmd_post_s   = wr_prmd_s   ? merge_wr(prmd_r,   csr_bus.csr_wdata, csr_bus.csr_wmask, W_PRMD)   : prmd_r;
  assign ecfg_post_s   = wr_ecfg_s   ? merge_wr(ecfg_r,   csr_bus.csr_wdata, csr_bus.csr_wmask, W_ECFG)   : ecfg_r;
  assign era_post_s    = wr_era_s    ? merge_wr(era_r,    csr_bus.csr_wdata, csr_bus.csr_wmask, W_ALL)    : era_r;
  assign badv_post_s   = wr_badv_s   ? merge_wr(badv_r,   csr_bus.csr_wdata, csr_bus.csr_wmask, W_ALL)    : badv_r;
  assign eentry_post_s = wr_eentry_s ? merge_wr(eentry_r, csr_bus.csr_wdata, csr_bus.csr_wmask, W_EENTRY) : eentry_r;
  assign tid_post_s    = wr_tid_s    ? merge_wr(tid_r,    csr_bus.csr_wdata, csr_bus.csr_wmask, W_ALL)    : tid_r;
  assign tcfg_post_s   = wr_tcfg_s   ? merge_wr(tcfg_r,   csr_bus.csr_wdata, csr_bus.csr_wmask, W_TCFG)   : tcfg_r;
  assign swi_post_s    = wr_estat_s  ? ((swi_r & ~csr_bus.csr_wmask[1:0]) | (csr_bus.csr_wdata[1:0] & csr_bus.csr_wmask[1:0]))
                                     : swi_r;
  assign save_wv_s     = merge_wr(save_r[widx_s], csr_bus.csr_wdata, csr_bus.csr_wmask, W_ALL);
  assign save_rv_s     = (save_wr_s && (csr_bus.csr_waddr == csr_bus.csr_raddr)) ? save_wv_s : save_r[ridx_s];

  assign ticlr_s    = wr_ticlr_s && csr_bus.csr_wdata[0] && csr_bus.csr_wmask[0];
  assign expire_s   = tcfg_r[0] && (timer_r == TIMER_ZERO);
  assign exc_take_s = exc_sig && !ertn;

  assign is_s         = {ipi_r, ti_r, 1'b0, hwi_r, swi_r};
  assign estat_view_s = {1'b0, esub_r, ecode_r, 3'b000, ipi_r, ti_r && !ticlr_s, 1'b0, hwi_r, swi_post_s};

  assign int_out    = (|(ecfg_r[12:0] & is_s)) && crmd_r[2];
  assign era_out    = era_post_s;
  assign eentry_out = eentry_post_s;
  assign csr_bus.csr_rdata = rdata_s;

  // CRMD/PRMD next state: ERTN restores, an exception saves and masks.
  always_comb begin
    crmd_nxt_s = crmd_post_s;
    prmd_nxt_s = prmd_post_s;
    if (ertn) begin
      crmd_nxt_s = {crmd_post_s[31:3], prmd_post_s[2:0]};
    end else if (exc_take_s) begin
      crmd_nxt_s = {crmd_post_s[31:3], 3'b000};
      prmd_nxt_s = {29'h0000_0000, crmd_post_s[2:0]};
    end else begin
      crmd_nxt_s = crmd_post_s;
    end
  end

  // Combinational read mux over the post-write views.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (csr_bus.csr_raddr)
      ADDR_CRMD:   rdata_s = crmd_post_s;
      ADDR_PRMD:   rdata_s = prmd_post_s;
      ADDR_ECFG:   rdata_s = ecfg_post_s;
      ADDR_ESTAT:  rdata_s = estat_view_s;
      ADDR_ERA:    rdata_s = era_post_s;
      ADDR_BADV:   rdata_s = badv_post_s;
      ADDR_EENTRY: rdata_s = eentry_post_s;
      ADDR_TID:    rdata_s = tid_post_s;
      ADDR_TCFG:   rdata_s = tcfg_post_s;
      ADDR_TVAL:   rdata_s = 32'(timer_r);
      ADDR_TICLR:  rdata_s = 32'h0000_0000;
      default: begin
        if (save_rhit_s) rdata_s = save_rv_s;
        else             rdata_s = 32'h0000_0000;
      end
    endcase
  end

  // CSR state, timer and interrupt sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crmd_r   <= 32'h0000_0008;
      prmd_r   <= 32'h0000_0000;
      ecfg_r   <= 32'h0000_0000;
      era_r    <= 32'h0000_0000;
      badv_r   <= 32'h0000_0000;
      eentry_r <= 32'h0000_0000;
      tid_r    <= TID_RESET;
      tcfg_r   <= 32'h0000_0000;
      swi_r    <= 2'b00;
      hwi_r    <= 8'h00;
      ipi_r    <= 1'b0;
      ti_r     <= 1'b0;
      ecode_r  <= 6'h00;
      esub_r   <= 9'h000;
      timer_r  <= TIMER_ZERO;
      for (int i = 0; i < SAVE_DEPTH; i++) save_r[i] <= 32'h0000_0000;
    end else begin
      crmd_r   <= crmd_nxt_s;
      prmd_r   <= prmd_nxt_s;
      ecfg_r   <= ecfg_post_s;
      era_r    <= exc_take_s ? exc_pc : era_post_s;
      badv_r   <= (exc_take_s && exc_badv_we) ? exc_badv : badv_post_s;
      eentry_r <= eentry_post_s;
      tid_r    <= tid_post_s;
      swi_r    <= swi_post_s;
      {ipi_r, hwi_r} <= irq_smp_s;
      ecode_r  <= exc_take_s ? exc_ecode    : ecode_r;
      esub_r   <= exc_take_s ? exc_esubcode : esub_r;
      // Expiry set beats a same-cycle TICLR clear.
      ti_r     <= expire_s ? 1'b1 : (ticlr_s ? 1'b0 : ti_r);
      for (int i = 0; i < SAVE_DEPTH; i++) begin
        if (save_wr_s && (widx_s == SIDX_W'(i))) save_r[i] <= save_wv_s;
      end
      // A TCFG write reloads the timer ahead of any countdown activity.
      if (wr_tcfg_s) begin
        tcfg_r  <= tcfg_post_s;
        timer_r <= {tcfg_post_s[TIMER_WIDTH-1:2], 2'b00};
      end else if (tcfg_r[0]) begin
        if (timer_r != TIMER_ZERO) begin
          timer_r <= timer_r - TIMER_ONE;
        end else if (tcfg_r[1]) begin
          timer_r <= {tcfg_r[TIMER_WIDTH-1:2], 2'b00};
        end else begin
          tcfg_r  <= {tcfg_r[31:1], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_file_param.sv
module tb_csr_file_param;

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_UNMAP  = 14'h002;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE1  = 14'h031;
  localparam logic [13:0] A_SAVE2  = 14'h032;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;
  localparam logic [31:0] TID_A    = 32'h1234_5678;
  localparam int          NVEC     = 19;

  typedef struct {
    logic        we;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [13:0] raddr;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hwi_in;
  logic        ipi_in, exc_sig, exc_badv_we, ertn;
  logic [5:0]  exc_ecode;
  logic [8:0]  exc_esubcode;
  logic [31:0] exc_pc, exc_badv;
  logic [31:0] eentry_a, era_a, eentry_b, era_b;
  logic        int_a, int_b;
  logic [31:0] rv;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs [NVEC];

  always #5 clk = ~clk;

  csr_file_param_if bus_a ();
  csr_file_param_if bus_b ();

  assign bus_b.csr_we    = bus_a.csr_we;
  assign bus_b.csr_waddr = bus_a.csr_waddr;
  assign bus_b.csr_wdata = bus_a.csr_wdata;
  assign bus_b.csr_wmask = bus_a.csr_wmask;
  assign bus_b.csr_raddr = bus_a.csr_raddr;

  csr_file_param #(.TIMER_WIDTH(32), .NUM_SAVE(2), .HWI_SYNC(1), .TID_RESET(TID_A)) dut_a (
    .clk(clk), .rst(rst), .csr_bus(bus_a), .hwi_in(hwi_in), .ipi_in(ipi_in),
    .exc_sig(exc_sig), .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode), .exc_pc(exc_pc),
    .exc_badv_we(exc_badv_we), .exc_badv(exc_badv), .ertn(ertn),
    .eentry_out(eentry_a), .era_out(era_a), .int_out(int_a));

  csr_file_param #(.TIMER_WIDTH(32), .NUM_SAVE(4), .HWI_SYNC(0), .TID_RESET(32'h0)) dut_b (
    .clk(clk), .rst(rst), .csr_bus(bus_b), .hwi_in(hwi_in), .ipi_in(ipi_in),
    .exc_sig(exc_sig), .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode), .exc_pc(exc_pc),
    .exc_badv_we(exc_badv_we), .exc_badv(exc_badv), .ertn(ertn),
    .eentry_out(eentry_b), .era_out(era_b), .int_out(int_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    @(negedge clk);
    bus_a.csr_we = 1'b1; bus_a.csr_waddr = a; bus_a.csr_wdata = d; bus_a.csr_wmask = m;
    @(posedge clk); #1;
    bus_a.csr_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    bus_a.csr_raddr = a;
    #1;
    d = bus_a.csr_rdata;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; hwi_in = 8'h00; ipi_in = 1'b0; exc_sig = 1'b0; exc_badv_we = 1'b0; ertn = 1'b0;
    exc_ecode = 6'h00; exc_esubcode = 9'h000; exc_pc = 32'h0; exc_badv = 32'h0;
    bus_a.csr_we = 1'b0; bus_a.csr_waddr = 14'h0; bus_a.csr_wdata = 32'h0;
    bus_a.csr_wmask = 32'h0; bus_a.csr_raddr = 14'h0;

    vecs[0]  = '{1'b0, A_CRMD,   32'h0,         32'h0,         A_CRMD,   32'h0000_0008};
    vecs[1]  = '{1'b0, A_TID,    32'h0,         32'h0,         A_TID,    TID_A};
    vecs[2]  = '{1'b0, A_PRMD,   32'h0,         32'h0,         A_PRMD,   32'h0000_0000};
    vecs[3]  = '{1'b1, A_ECFG,   32'hFFFF_FFFF, 32'h0000_0803, A_ECFG,   32'h0000_0803};
    vecs[4]  = '{1'b0, A_ECFG,   32'h0,         32'h0,         A_ECFG,   32'h0000_0803};
    vecs[5]  = '{1'b1, A_ESTAT,  32'hFFFF_FFFF, 32'h0000_0803, A_ESTAT,  32'h0000_0003};
    vecs[6]  = '{1'b1, A_ESTAT,  32'h0000_0000, 32'h0000_0001, A_ESTAT,  32'h0000_0002};
    vecs[7]  = '{1'b1, A_EENTRY, 32'h1C00_8ABC, 32'hFFFF_FFFF, A_EENTRY, 32'h1C00_8A80};
    vecs[8]  = '{1'b1, A_SAVE1,  32'hA5A5_5A5A, 32'hFFFF_FFFF, A_SAVE0,  32'h0000_0000};
    vecs[9]  = '{1'b0, A_SAVE1,  32'h0,         32'h0,         A_SAVE1,  32'hA5A5_5A5A};
    vecs[10] = '{1'b1, A_SAVE2,  32'h0000_FFFF, 32'hFFFF_FFFF, A_SAVE2,  32'h0000_0000};
    vecs[11] = '{1'b1, A_TVAL,   32'h0000_1234, 32'hFFFF_FFFF, A_TVAL,   32'h0000_0000};
    vecs[12] = '{1'b1, A_CRMD,   32'hFFFF_FFFF, 32'h0000_0003, A_CRMD,   32'h0000_000B};
    vecs[13] = '{1'b1, A_UNMAP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, A_UNMAP,  32'h0000_0000};
    vecs[14] = '{1'b1, A_TID,    32'hCAFE_0000, 32'hFFFF_0000, A_TID,    32'hCAFE_5678};
    vecs[15] = '{1'b1, A_PRMD,   32'h0000_00FF, 32'hFFFF_FFFF, A_PRMD,   32'h0000_0007};
    vecs[16] = '{1'b1, A_TICLR,  32'h0000_0001, 32'h0000_0001, A_TICLR,  32'h0000_0000};
    vecs[17] = '{1'b1, A_TCFG,   32'hFFFF_FFFF, 32'h0000_0000, A_TCFG,   32'h0000_0000};
    vecs[18] = '{1'b1, A_SAVE0,  32'h1111_1111, 32'h0000_FFFF, A_SAVE0,  32'h0000_1111};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_int_a", {31'h0, int_a}, 32'h0);
    chk("reset_int_b", {31'h0, int_b}, 32'h0);
    chk("reset_era", era_a, 32'h0);
    chk("reset_eentry", eentry_a, 32'h0);

    // Table of single-cycle reads, masked writes and bypassed reads.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus_a.csr_we = vecs[i].we; bus_a.csr_waddr = vecs[i].waddr;
      bus_a.csr_wdata = vecs[i].wdata; bus_a.csr_wmask = vecs[i].wmask;
      bus_a.csr_raddr = vecs[i].raddr;
      #1;
      chk($sformatf("vec%0d", i), bus_a.csr_rdata, vecs[i].exp);
      @(posedge clk); #1;
      bus_a.csr_we = 1'b0;
    end
    bus_a.csr_raddr = A_SAVE2; #1;
    chk("save2_numsave4", bus_b.csr_rdata, 32'h0000_FFFF);

    // Interrupt latency: 2 cycles with the synchroniser, 1 without.
    do_reset();
    wr(A_ECFG, 32'h0000_0004, 32'hFFFF_FFFF);
    wr(A_CRMD, 32'h0000_0004, 32'hFFFF_FFFF);
    @(negedge clk);
    hwi_in = 8'h01;
    #1;
    chk("irq_c0_a", {31'h0, int_a}, 32'h0);
    chk("irq_c0_b", {31'h0, int_b}, 32'h0);
    tick(1);
    chk("irq_c1_a", {31'h0, int_a}, 32'h0);
    chk("irq_c1_b", {31'h0, int_b}, 32'h1);
    tick(1);
    chk("irq_c2_a", {31'h0, int_a}, 32'h1);
    hwi_in = 8'h00;

    // One-shot timer: InitVal=5, En=1.
    do_reset();
    wr(A_TCFG, 32'h0000_0015, 32'hFFFF_FFFF);
    for (int k = 0; k <= 20; k++) begin
      rd(A_TVAL, rv);
      chk($sformatf("oneshot_tval%0d", k), rv, 32'(20 - k));
      tick(1);
    end
    rd(A_ESTAT, rv); chk("oneshot_ti", rv & 32'h0000_0800, 32'h0000_0800);
    rd(A_TCFG, rv);  chk("oneshot_en_clr", rv, 32'h0000_0014);
    tick(3);
    rd(A_TVAL, rv);  chk("oneshot_hold", rv, 32'h0);
    rd(A_ESTAT, rv); chk("oneshot_ti_hold", rv & 32'h0000_0800, 32'h0000_0800);
    wr(A_TICLR, 32'h0000_0001, 32'hFFFF_FFFF);
    rd(A_ESTAT, rv); chk("ticlr_clear", rv & 32'h0000_0800, 32'h0);

    // Periodic timer, TICLR alone and TICLR coinciding with expiry.
    do_reset();
    wr(A_TCFG, 32'h0000_0017, 32'hFFFF_FFFF);
    tick(21);
    rd(A_TVAL, rv);  chk("periodic_reload", rv, 32'd20);
    rd(A_ESTAT, rv); chk("periodic_ti1", rv & 32'h0000_0800, 32'h0000_0800);
    wr(A_TICLR, 32'h0000_0001, 32'hFFFF_FFFF);
    rd(A_ESTAT, rv); chk("periodic_ticlr", rv & 32'h0000_0800, 32'h0);
    rd(A_TVAL, rv);  chk("periodic_tval19", rv, 32'd19);
    tick(19);
    rd(A_TVAL, rv);  chk("periodic_tval0", rv, 32'd0);
    wr(A_TICLR, 32'h0000_0001, 32'hFFFF_FFFF);
    rd(A_ESTAT, rv); chk("ticlr_vs_expiry", rv & 32'h0000_0800, 32'h0000_0800);
    rd(A_TVAL, rv);  chk("periodic_reload2", rv, 32'd20);

    // Asynchronous reset in the middle of a count.
    tick(5);
    #2;
    rst = 1'b1;
    rd(A_TVAL, rv);  chk("midrst_tval", rv, 32'h0);
    rd(A_ESTAT, rv); chk("midrst_estat", rv, 32'h0);
    chk("midrst_int", {31'h0, int_a}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    rd(A_TVAL, rv);  chk("postrst_tval", rv, 32'h0);
    rd(A_CRMD, rv);  chk("postrst_crmd", rv, 32'h0000_0008);

    // Exception with a same-cycle CRMD write.
    @(negedge clk);
    bus_a.csr_we = 1'b1; bus_a.csr_waddr = A_CRMD; bus_a.csr_wdata = 32'h7; bus_a.csr_wmask = 32'hFFFF_FFFF;
    exc_sig = 1'b1; exc_ecode = 6'h08; exc_esubcode = 9'h000; exc_pc = 32'h1C00_0100;
    exc_badv_we = 1'b1; exc_badv = 32'hDEAD_BEE0;
    @(posedge clk); #1;
    bus_a.csr_we = 1'b0; exc_sig = 1'b0; exc_badv_we = 1'b0;
    rd(A_PRMD, rv);  chk("exc_prmd", rv, 32'h0000_0007);
    rd(A_CRMD, rv);  chk("exc_crmd_plv_ie", rv & 32'h7, 32'h0);
    rd(A_ERA, rv);   chk("exc_era", rv, 32'h1C00_0100);
    rd(A_BADV, rv);  chk("exc_badv", rv, 32'hDEAD_BEE0);
    rd(A_ESTAT, rv); chk("exc_ecode", (rv >> 16) & 32'h3F, 32'h08);
    chk("exc_era_out", era_a, 32'h1C00_0100);

    // ERTN with a same-cycle PRMD write.
    @(negedge clk);
    bus_a.csr_we = 1'b1; bus_a.csr_waddr = A_PRMD; bus_a.csr_wdata = 32'h5; bus_a.csr_wmask = 32'hFFFF_FFFF;
    ertn = 1'b1;
    @(posedge clk); #1;
    bus_a.csr_we = 1'b0; ertn = 1'b0;
    rd(A_CRMD, rv);  chk("ertn_crmd", rv & 32'h7, 32'h5);

    // ERTN and exception together: only the ERTN takes effect.
    wr(A_PRMD, 32'h0000_0002, 32'hFFFF_FFFF);
    @(negedge clk);
    ertn = 1'b1; exc_sig = 1'b1; exc_ecode = 6'h3F; exc_pc = 32'h1111_0000;
    exc_badv_we = 1'b1; exc_badv = 32'h0000_0000;
    @(posedge clk); #1;
    ertn = 1'b0; exc_sig = 1'b0; exc_badv_we = 1'b0;
    rd(A_CRMD, rv);  chk("both_crmd", rv & 32'h7, 32'h2);
    rd(A_ERA, rv);   chk("both_era", rv, 32'h1C00_0100);
    rd(A_PRMD, rv);  chk("both_prmd", rv, 32'h2);
    tick(0);
    rd(A_ESTAT, rv); chk("both_ecode", (rv >> 16) & 32'h3F, 32'h08);
    rd(A_BADV, rv);  chk("both_badv", rv, 32'hDEAD_BEE0);

    // ERA / EENTRY bypass outputs.
    @(negedge clk);
    bus_a.csr_we = 1'b1; bus_a.csr_waddr = A_ERA; bus_a.csr_wdata = 32'h1234_5678; bus_a.csr_wmask = 32'hFFFF_0000;
    #1;
    chk("era_bypass", era_a, 32'h1234_0100);
    @(posedge clk); #1;
    bus_a.csr_we = 1'b0;
    chk("era_reg", era_a, 32'h1234_0100);
    @(negedge clk);
    bus_a.csr_we = 1'b1; bus_a.csr_waddr = A_EENTRY; bus_a.csr_wdata = 32'hFFFF_FFFF; bus_a.csr_wmask = 32'hFFFF_FFFF;
    #1;
    chk("eentry_bypass", eentry_a, 32'hFFFF_FFC0);
    @(posedge clk); #1;
    bus_a.csr_we = 1'b0;
    chk("eentry_reg", eentry_a, 32'hFFFF_FFC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_file_param.md
Name: csr_file_param

Overview:
Parametrised LoongArch-style control/status register file, successor to the fixed single-timer CSR block. It adds a configurable timer width, a configurable SAVE bank, masked writes for csrxchg, BADV capture, optional hardware-interrupt synchronisers and TCFG-triggered timer load. It sits beside the integer register file. The read port is used in the EX stage, the write port is driven from WB, and exception/ERTN events come from the pipeline.

Parameters:
TIMER_WIDTH, 32, width of the countdown timer and of the TCFG InitVal field; legal range 8..32.
NUM_SAVE, 4, number of SAVEn registers (SAVE0 at 0x30 upward); legal range 1..16.
HWI_SYNC, 1, 1 puts a two-flop synchroniser on hwi_in/ipi_in; 0 uses a single sampling flop.
TID_RESET, 0, reset value of TID.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
csr_we  in  1  write enable (WB)
csr_waddr  in  14  write CSR number
csr_wdata  in  32  write data
csr_wmask  in  32  bit mask; csrwr drives all-ones
csr_raddr  in  14  read CSR number
csr_rdata  out  32  read data, combinational
hwi_in  in  8  external hardware interrupt lines
ipi_in  in  1  inter-processor interrupt
exc_sig  in  1  exception commit pulse
exc_ecode  in  6  Ecode
exc_esubcode  in  9  EsubCode
exc_pc  in  32  faulting PC
exc_badv_we  in  1  exception carries a bad virtual address
exc_badv  in  32  bad virtual address
ertn  in  1  exception return pulse
eentry_out  out  32  exception entry, bypassed from the write port
era_out  out  32  ERA, bypassed from the write port
int_out  out  1  pending enabled interrupt AND CRMD.IE

Behaviour:
- Address map: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE 0x30..0x30+NUM_SAVE-1, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44. Unmapped addresses read 0 and ignore writes.
- Field layout:
  - CRMD: PLV[1:0], IE[2], DA[3], PG[4].
  - PRMD: PPLV[1:0], PIE[2].
  - ECFG: LIE[9:0], LIE[12:11].
  - ESTAT: IS[1:0] SWI, IS[9:2] HWI, IS[11] TI, IS[12] IPI, Ecode[21:16], EsubCode[30:22].
  - TCFG: En[0], Periodic[1], InitVal[TIMER_WIDTH-1:2].
- Reset values: CRMD=0x8; PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVEn, TCFG = 0; TID=TID_RESET; timer=0. Resulting outputs: int_out=0, era_out=0, eentry_out=0.
- Masked write: new = (old & ~wmask) | (wdata & wmask), restricted to writable bits.
  - Read-only or reserved bits keep their value and read 0 where reserved.
  - ESTAT: only IS[1:0] is software-writable.
  - TVAL: read-only.
  - TICLR: a write with the effective bit 0 = 1 clears ESTAT.TI; TICLR reads 0.
- Read: combinational. If csr_we and csr_waddr==csr_raddr, csr_rdata returns the merged post-write value (same-cycle bypass).
  - The ESTAT read reflects a same-cycle TICLR clear.
  - The TVAL read returns the zero-extended timer.
- Timer:
  - A TCFG write loads timer <= {InitVal,2'b00} from the new value; this takes priority over the decrement.
  - Otherwise, when En=1 and timer!=0, timer decrements by 1 each cycle.
  - When En=1 and timer==0: ESTAT.TI is set. If Periodic=1, timer reloads {InitVal,00}. Otherwise En clears and timer holds 0.
  - Expiry and a TICLR clear in the same cycle: set wins, TI=1.
- Interrupt sampling: HWI/IPI are captured into ESTAT through 1 or 2 flops (HWI_SYNC), giving a 1- or 2-cycle latency.
- int_out: |(LIE & IS) & CRMD.IE, computed from registered state.
- Exception (exc_sig=1, ertn=0):
  - PRMD.PPLV/PIE <= CRMD.PLV/IE, using the post-write value if CRMD is written in the same cycle.
  - CRMD.PLV<=0, CRMD.IE<=0.
  - ERA<=exc_pc.
  - ESTAT.Ecode/EsubCode <= inputs.
  - BADV<=exc_badv if exc_badv_we.
  - These fields override a same-cycle CSR write to them.
- ERTN: CRMD.PLV/IE <= PRMD.PPLV/PIE, using the post-write PRMD if written in the same cycle. ertn has priority over exc_sig.
- Bypass outputs: era_out and eentry_out return the merged write value when the same-cycle write targets ERA or EENTRY; otherwise the register. eentry_out bits [5:0] read 0.
- Async reset mid-count: timer and all state return to reset values at once; no interrupt is pending afterwards.

Test Plan:
- Reset -> csr_rdata for CRMD = 0x8, for TID = TID_RESET, int_out=0.
- Masked write: ECFG=0, csr_wdata=0xFFFF_FFFF, csr_wmask=0x0000_0803 -> ECFG reads 0x803.
  - The same write targeting ESTAT -> only bits [1:0] change.
- Timer, one-shot: write TCFG=0x15 (InitVal=5, En=1) -> TVAL counts 20..0, TI=1 the next cycle, En=0, TVAL holds 0.
  - Same with Periodic=1 (TCFG=0x17) -> reload to 20, TI pulses repeatedly.
  - TICLR write with bit 0 = 1 -> TI=0, except when it coincides with expiry, in which case TI stays 1.
- Interrupt: ECFG.LIE[2]=1, CRMD.IE=1, hwi_in[0] set -> int_out rises 2 cycles later (HWI_SYNC=1) and 1 cycle later (HWI_SYNC=0).
- Exception with a same-cycle CRMD write of 0x7:
  - Stimulus: exc_sig, exc_ecode=0x8, exc_pc=0x1C00_0100, exc_badv_we=1, exc_badv=0xDEAD_BEE0.
  - Required: PRMD=0x7, CRMD.PLV=0, CRMD.IE=0, ERA=0x1C00_0100, BADV=0xDEAD_BEE0, ESTAT[21:16]=0x8.
- ERTN with a same-cycle PRMD write of 0x5 -> CRMD.PLV=1, CRMD.IE=1. ertn together with exc_sig -> ERTN result only.
- NUM_SAVE=2: write 0x31 -> readback matches; write 0x32 -> reads 0.
